// File: rtl/sorted_ram_pkg.sv
// Shared sizes and the writer FSM state type for the sorted-array search memory.
package sorted_ram_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CMP  = 2'd2,
    S_WR   = 2'd3
  } wr_state_t;
endpackage

// File: rtl/sorted_ram_writer_if.sv
// Value-insert handshake into the sorted RAM writer.
interface sorted_ram_writer_if;
  import sorted_ram_pkg::*;

  // valid/ready: the producer holds in_valid and in_data stable until it sees
  // in_ready; a value moves on any rising clk edge where both are high, and
  // in_ready never depends combinationally on in_valid.
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ram32x8_dp.sv
// 32x8 RAM: one write port and two registered read ports (writer side and search side).
module ram32x8_dp
  import sorted_ram_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    ra_data <= mem[ra_addr];
    rb_data <= mem[rb_addr];
  end
endmodule

// File: rtl/sorted_ram_writer.sv
// Inserts values one at a time into an external RAM, keeping entries [0..count-1]
// in ascending unsigned order by shifting larger entries up one slot.
module sorted_ram_writer
  import sorted_ram_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  sorted_ram_writer_if.slave  in_if,
  input  logic                clear,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                busy,
  output logic                done,
  output wr_state_t           state_dbg
);
  wr_state_t         state;
  logic [DATA_W-1:0] val;
  logic [CNT_W-1:0]  idx;
  logic [ADDR_W-1:0] slot;
  logic              take;
  logic              shift;

  // idx never exceeds count-at-accept, which is below DEPTH, so it fits a RAM address.
  assign slot = idx[ADDR_W-1:0];

  assign full           = (count == DEPTH_CNT);
  assign in_if.in_ready = (state == S_IDLE) && !full && !clear;
  assign take           = in_if.in_valid && in_if.in_ready;
  assign shift          = (state == S_CMP) && (rd_data > val);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_WR);
  assign wr_en          = shift || done;
  assign wr_addr        = slot;
  assign wr_data        = done ? val : rd_data;
  assign state_dbg      = state;

  // Reading slot-1 whenever busy keeps the read address off the write address,
  // including the wrap to the top slot when the final write lands at 0.
  assign rd_addr = (state == S_IDLE) ? '0 : (slot - ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      val   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            count <= '0;
          end else if (take) begin
            val   <= in_if.in_data;
            idx   <= count;
            state <= (count == '0) ? S_WR : S_RD;
          end
        end
        S_RD: begin
          state <= S_CMP;
        end
        S_CMP: begin
          // Strict compare: equal entries stay below the new value.
          if (shift) begin
            idx   <= idx - CNT_W'(1);
            state <= (idx == CNT_W'(1)) ? S_WR : S_RD;
          end else begin
            state <= S_WR;
          end
        end
        S_WR: begin
          count <= count + CNT_W'(1);
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sorted_ram_writer.sv
// Directed bench for sorted_ram_writer: sorted-queue model, per-cycle compare, RAM dumps.
module tb_sorted_ram_writer;
  import sorted_ram_pkg::*;

  logic              clk;
  logic              reset;
  logic              clear;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              busy;
  logic              done;
  wr_state_t         state_dbg;
  logic [ADDR_W-1:0] rdb_addr;
  logic [DATA_W-1:0] rdb_data;

  sorted_ram_writer_if wif ();

  sorted_ram_writer dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (wif.slave),
    .clear     (clear),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  ram32x8_dp ram (
    .clk     (clk),
    .we      (wr_en),
    .wa      (wr_addr),
    .wd      (wr_data),
    .ra_addr (rd_addr),
    .ra_data (rd_data),
    .rb_addr (rdb_addr),
    .rb_data (rdb_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cur_n = 0;
  logic chk_en = 1'b0;
  logic [7:0]  model [$];
  // {rd_chk, rd_addr[4:0], wr_en, wr_addr[4:0], wr_data[7:0], done}
  logic [20:0] exp_q [$];
  logic [12:0] wlog  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] mk(input logic rc, input int ra, input logic we,
                                     input int wa, input logic [7:0] wd, input logic dn);
    return {rc, 5'(ra), we, 5'(wa), wd, dn};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [20:0] e;
    if (chk_en) begin
      if (wr_en) wlog.push_back({wr_addr, wr_data});
      if (wr_en) check("rd_wr_collide", 32'(rd_addr == wr_addr), 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy_ins",  32'(busy), 32'd1);
        check("ready_ins", 32'(wif.in_ready), 32'd0);
        check("count_ins", 32'(count), 32'(cur_n));
        check("wr_en",     32'(wr_en), 32'(e[14]));
        check("done",      32'(done),  32'(e[0]));
        if (e[20]) check("rd_addr", 32'(rd_addr), 32'(e[19:15]));
        if (e[14]) begin
          check("wr_addr", 32'(wr_addr), 32'(e[13:9]));
          check("wr_data", 32'(wr_data), 32'(e[8:1]));
        end
      end else begin
        check("wr_en_idle", 32'(wr_en), 32'd0);
        check("done_idle",  32'(done),  32'd0);
        check("busy_idle",  32'(busy),  32'd0);
        check("count_idle", 32'(count), 32'(model.size()));
        check("full_idle",  32'(full),  32'(model.size() == 32));
        check("ready_idle", 32'(wif.in_ready), 32'((model.size() < 32) && !clear));
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic do_insert(input logic [7:0] v);
    int n;
    int p;
    int guard;
    wlog.delete();
    wif.in_valid = 1'b1;
    wif.in_data  = v;
    @(posedge clk); #1;
    wif.in_valid = 1'b0;
    n = model.size();
    p = 0;
    while (p < n && model[p] <= v) p++;
    cur_n = n;
    if (n > 0) begin
      for (int k = n - 1; k >= p; k--) begin
        exp_q.push_back(mk(1'b1, k, 1'b0, 0, 8'h00, 1'b0));
        exp_q.push_back(mk(1'b0, 0, 1'b1, k + 1, model[k], 1'b0));
      end
      if (p > 0) begin
        exp_q.push_back(mk(1'b1, p - 1, 1'b0, 0, 8'h00, 1'b0));
        exp_q.push_back(mk(1'b0, 0, 1'b0, 0, 8'h00, 1'b0));
      end
    end
    exp_q.push_back(mk(1'b0, 0, 1'b1, p, v, 1'b1));
    model.insert(p, v);
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("insert_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model.delete();
  endtask

  task automatic dump(input string tag);
    for (int i = 0; i < model.size(); i++) begin
      rdb_addr = 5'(i);
      @(posedge clk); #1;
      check(tag, 32'(rdb_data), 32'(model[i]));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] exp3 [4];
    logic [7:0] exp4 [4];
    exp3 = '{8'd10, 8'd30, 8'd40, 8'd50};
    exp4 = '{8'd5, 8'd20, 8'd20, 8'd20};
    reset = 1'b1;
    clear = 1'b0;
    wif.in_valid = 1'b0;
    wif.in_data  = '0;
    rdb_addr = '0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full",  32'(full), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(wif.in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 2: insert into empty array
    do_insert(8'd50);
    check("t2_writes", 32'(wlog.size()), 32'd1);
    check("t2_write0", 32'(wlog[0]), {19'd0, 5'd0, 8'd50});
    dump("t2_mem");

    // 3: insertion with shifts
    do_insert(8'd30);
    do_insert(8'd10);
    check("t3_nwrites", 32'(wlog.size()), 32'd3);
    check("t3_shift_a", 32'(wlog[0]), {19'd0, 5'd2, 8'd50});
    check("t3_shift_b", 32'(wlog[1]), {19'd0, 5'd1, 8'd30});
    check("t3_final",   32'(wlog[2]), {19'd0, 5'd0, 8'd10});
    do_insert(8'd40);
    check("t3_size", 32'(model.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t3_model", 32'(model[i]), 32'(exp3[i]));
    dump("t3_mem");

    // 4: equal values land after existing equals
    do_clear();
    do_insert(8'd20);
    do_insert(8'd20);
    do_insert(8'd5);
    do_insert(8'd20);
    check("t4_nwrites", 32'(wlog.size()), 32'd1);
    check("t4_final",   32'(wlog[0]), {19'd0, 5'd3, 8'd20});
    for (int i = 0; i < 4; i++) check("t4_model", 32'(model[i]), 32'(exp4[i]));
    dump("t4_mem");

    // 5: fill to DEPTH with descending values, then push against full
    do_clear();
    for (int v = 255; v >= 224; v--) do_insert(8'(v));
    check("t5_last_writes", 32'(wlog.size()), 32'd32);
    for (int i = 0; i < 32; i++) check("t5_model", 32'(model[i]), 32'(224 + i));
    dump("t5_mem");
    wlog.delete();
    wif.in_valid = 1'b1;
    wif.in_data  = 8'd1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    wif.in_valid = 1'b0;
    check("t5_full_writes", 32'(wlog.size()), 32'd0);
    check("t5_full_count", 32'(count), 32'd32);
    check("t5_full_flag", 32'(full), 32'd1);

    // 6a: reset during CMP of a shifting insert
    do_clear();
    do_insert(8'd20);
    do_insert(8'd30);
    do_insert(8'd40);
    wif.in_valid = 1'b1;
    wif.in_data  = 8'd10;
    @(posedge clk); #1;
    wif.in_valid = 1'b0;
    chk_en = 1'b0;
    @(posedge clk); #1;
    check("t6_in_cmp", 32'(state_dbg), 32'(S_CMP));
    reset = 1'b1;
    @(negedge clk);
    check("t6_cmp_wr_en",   32'(wr_en), 32'd1);
    check("t6_cmp_wr_addr", 32'(wr_addr), 32'd3);
    check("t6_cmp_wr_data", 32'(wr_data), 32'd40);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_wr_en", 32'(wr_en), 32'd0);
    check("t6_rst_ready", 32'(wif.in_ready), 32'd1);
    model.delete();
    exp_q.delete();
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 6b: clear beats a simultaneous transfer
    do_insert(8'd7);
    do_insert(8'd3);
    clear = 1'b1;
    wif.in_valid = 1'b1;
    wif.in_data  = 8'd9;
    @(posedge clk); #1;
    clear = 1'b0;
    wif.in_valid = 1'b0;
    model.delete();
    @(negedge clk);
    check("t6_clear_count", 32'(count), 32'd0);
    check("t6_clear_busy",  32'(busy), 32'd0);
    @(posedge clk); #1;
    do_insert(8'd9);
    dump("t6_mem");
    repeat (2) @(posedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
